// File: rtl/for_ent_inverse.sv
// for_ent_inverse: bit-serial inverse of XOUT = (K*A - B) mod 2^WIDTH, K = COUNT+1.
// Recovers A one bit per clock from (XIN + B), then re-applies the forward
// kernel to the result to produce a self-check flag.
module for_ent_inverse #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned COUNT = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] XIN,
   input  logic [WIDTH-1:0] B,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] AOUT,
   output logic             CHECK_OK
);

   localparam int unsigned K  = COUNT + 1;
   localparam int unsigned KW = $clog2(K + 1);
   localparam int unsigned PW = WIDTH + KW;
   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // An even K has no inverse mod 2^WIDTH, so an odd COUNT cannot be solved.
   if ((COUNT % 2) != 0) begin : g_bad_count
      $error("for_ent_inverse: COUNT must be even so that K = COUNT+1 is odd");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SOLVE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_xl;
   logic [WIDTH-1:0] r_bl;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_acc;
   logic [IW-1:0]    r_idx;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_aout;
   logic             r_check_ok;

   state_t           w_state_nx;
   logic [WIDTH-1:0] w_xl_nx;
   logic [WIDTH-1:0] w_bl_nx;
   logic [WIDTH-1:0] w_res_nx;
   logic [WIDTH-1:0] w_acc_nx;
   logic [IW-1:0]    w_idx_nx;
   logic             w_in_ready_nx;
   logic             w_out_valid_nx;
   logic [WIDTH-1:0] w_aout_nx;
   logic             w_check_ok_nx;

   logic [PW-1:0]    w_kacc_full;
   logic [WIDTH-1:0] w_kacc;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_bit;
   logic             w_check;
   logic             w_unused_hi;

   // K*acc at full width, then truncated; d = r - K*acc drives the next bit.
   assign w_kacc_full = PW'(K) * PW'(r_acc);
   assign w_kacc      = w_kacc_full[WIDTH-1:0];
   assign w_unused_hi = ^w_kacc_full[PW-1:WIDTH];
   assign w_diff      = r_res - w_kacc;
   assign w_bit       = WIDTH'(1) << r_idx;
   assign w_check     = ((w_kacc - r_bl) == r_xl);

   // Next-state and next-register values for every state.
   always_comb begin
      w_state_nx     = r_state;
      w_xl_nx        = r_xl;
      w_bl_nx        = r_bl;
      w_res_nx       = r_res;
      w_acc_nx       = r_acc;
      w_idx_nx       = r_idx;
      w_in_ready_nx  = r_in_ready;
      w_out_valid_nx = r_out_valid;
      w_aout_nx      = r_aout;
      w_check_ok_nx  = r_check_ok;

      case (r_state)
         S_IDLE: begin
            if (IN_VALID && r_in_ready) begin
               w_xl_nx       = XIN;
               w_bl_nx       = B;
               w_res_nx      = XIN + B;
               w_acc_nx      = '0;
               w_idx_nx      = '0;
               w_in_ready_nx = 1'b0;
               w_state_nx    = S_SOLVE;
            end
         end
         S_SOLVE: begin
            // Setting acc[i] adds K*2^i, which flips bit i of K*acc and leaves lower bits intact.
            if (w_diff[r_idx]) begin
               w_acc_nx = r_acc | w_bit;
            end
            w_idx_nx = r_idx + IW'(1);
            if (r_idx == IW'(WIDTH - 1)) begin
               w_state_nx = S_CHECK;
            end
         end
         S_CHECK: begin
            w_aout_nx      = r_acc;
            w_check_ok_nx  = w_check;
            w_out_valid_nx = 1'b1;
            w_state_nx     = S_DONE;
         end
         S_DONE: begin
            // Output handshake only; a new job is accepted in IDLE on the following cycle.
            if (OUT_READY) begin
               w_out_valid_nx = 1'b0;
               w_in_ready_nx  = 1'b1;
               w_state_nx     = S_IDLE;
            end
         end
         default: begin
            w_out_valid_nx = 1'b0;
            w_in_ready_nx  = 1'b1;
            w_state_nx     = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state     <= S_IDLE;
         r_xl        <= '0;
         r_bl        <= '0;
         r_res       <= '0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_aout      <= '0;
         r_check_ok  <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_xl        <= w_xl_nx;
         r_bl        <= w_bl_nx;
         r_res       <= w_res_nx;
         r_acc       <= w_acc_nx;
         r_idx       <= w_idx_nx;
         r_in_ready  <= w_in_ready_nx;
         r_out_valid <= w_out_valid_nx;
         r_aout      <= w_aout_nx;
         r_check_ok  <= w_check_ok_nx;
      end
   end

   assign IN_READY  = r_in_ready;
   assign OUT_VALID = r_out_valid;
   assign AOUT      = r_aout;
   assign CHECK_OK  = r_check_ok;

endmodule

// File: tb/tb_for_ent_inverse.sv
// Directed and random self-checking bench for for_ent_inverse (WIDTH=8, K=5).
module tb_for_ent_inverse;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned COUNT = 4;

   logic             CLK = 1'b0;
   logic             RST_N = 1'b0;
   logic             IN_VALID = 1'b0;
   logic             IN_READY;
   logic [WIDTH-1:0] XIN = '0;
   logic [WIDTH-1:0] B = '0;
   logic             OUT_VALID;
   logic             OUT_READY = 1'b0;
   logic [WIDTH-1:0] AOUT;
   logic             CHECK_OK;

   int n_checks = 0;
   int n_fail   = 0;

   for_ent_inverse #(.WIDTH(WIDTH), .COUNT(COUNT)) u_dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .XIN       (XIN),
      .B         (B),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .AOUT      (AOUT),
      .CHECK_OK  (CHECK_OK)
   );

   // Free-running clock
   always #5 CLK = ~CLK;

   // Single comparison point: counts and reports mismatches
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One job: accept, measure latency, optional backpressure, output handshake
   task automatic run_job(input string tag, input logic [7:0] xin, input logic [7:0] b,
                          input logic [7:0] exp_a, input int hold);
      int  guard;
      int  lat;
      bit  rdy_leak;
      guard = 0;
      while (!IN_READY && guard < 100) begin
         tick();
         guard++;
      end
      check_eq({tag, " in_ready_before"}, 32'(IN_READY), 32'd1);
      XIN      = xin;
      B        = b;
      IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      lat      = 0;
      rdy_leak = 1'b0;
      while (!OUT_VALID && lat < 50) begin
         if (IN_READY) rdy_leak = 1'b1;
         tick();
         lat++;
      end
      check_eq({tag, " latency"}, 32'(lat), 32'd9);
      check_eq({tag, " in_ready_busy"}, 32'(rdy_leak | IN_READY), 32'd0);
      check_eq({tag, " aout"}, 32'(AOUT), 32'(exp_a));
      check_eq({tag, " check_ok"}, 32'(CHECK_OK), 32'd1);
      for (int h = 0; h < hold; h++) begin
         tick();
         check_eq({tag, " hold_valid"}, 32'(OUT_VALID), 32'd1);
         check_eq({tag, " hold_aout"}, 32'(AOUT), 32'(exp_a));
         check_eq({tag, " hold_in_ready"}, 32'(IN_READY), 32'd0);
      end
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      check_eq({tag, " valid_drop"}, 32'(OUT_VALID), 32'd0);
      check_eq({tag, " in_ready_back"}, 32'(IN_READY), 32'd1);
      check_eq({tag, " aout_kept"}, 32'(AOUT), 32'(exp_a));
   endtask

   // Watchdog so the run always terminates
   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a;
      int b;
      logic [7:0] xv;
      int cyc;
      int last_hs;
      int n_acc;
      bit acc_now;
      bit hs_now;

      // Reset held three cycles
      RST_N = 1'b0;
      repeat (3) tick();
      RST_N = 1'b1;
      check_eq("reset in_ready", 32'(IN_READY), 32'd1);
      check_eq("reset out_valid", 32'(OUT_VALID), 32'd0);
      check_eq("reset aout", 32'(AOUT), 32'd0);
      check_eq("reset check_ok", 32'(CHECK_OK), 32'd0);

      // Basic and wrap-around vectors: 5*A - B mod 256 == XIN
      run_job("basic", 8'd32, 8'd3, 8'd7, 0);
      run_job("wrap200", 8'd222, 8'd10, 8'd200, 0);
      run_job("wrap0", 8'd255, 8'd1, 8'd0, 0);
      run_job("wrap255", 8'd252, 8'd255, 8'd255, 0);

      // Backpressure for five cycles
      run_job("bp", 8'd32, 8'd3, 8'd7, 5);

      // Reset on the fourth SOLVE edge abandons the job
      XIN      = 8'd32;
      B        = 8'd3;
      IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      repeat (3) tick();
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check_eq("midrst in_ready", 32'(IN_READY), 32'd1);
      check_eq("midrst out_valid", 32'(OUT_VALID), 32'd0);
      check_eq("midrst aout", 32'(AOUT), 32'd0);
      check_eq("midrst check_ok", 32'(CHECK_OK), 32'd0);
      repeat (12) begin
         tick();
         check_eq("midrst no_output", 32'(OUT_VALID), 32'd0);
      end
      run_job("after_rst", 8'd222, 8'd10, 8'd200, 0);

      // Random sweep against the forward kernel
      for (int n = 0; n < 1000; n++) begin
         a  = int'($urandom_range(0, 255));
         b  = int'($urandom_range(0, 255));
         xv = 8'(5 * a - b);
         run_job("rand", xv, 8'(b), 8'(a), 0);
      end

      // Back-to-back with IN_VALID held: each accept one edge after the output handshake
      XIN       = 8'd32;
      B         = 8'd3;
      IN_VALID  = 1'b1;
      OUT_READY = 1'b1;
      cyc       = 0;
      last_hs   = -1;
      n_acc     = 0;
      repeat (40) begin
         acc_now = IN_VALID && IN_READY;
         hs_now  = OUT_VALID && OUT_READY;
         if (hs_now) begin
            check_eq("b2b aout", 32'(AOUT), 32'd7);
            check_eq("b2b check_ok", 32'(CHECK_OK), 32'd1);
            check_eq("b2b no_overlap", 32'(IN_READY), 32'd0);
         end
         tick();
         cyc++;
         if (hs_now) last_hs = cyc;
         if (acc_now) begin
            n_acc++;
            if (last_hs >= 0) check_eq("b2b accept_gap", 32'(cyc - last_hs), 32'd1);
         end
      end
      check_eq("b2b accepts", 32'(n_acc >= 3), 32'd1);
      IN_VALID = 1'b0;
      repeat (15) tick();
      check_eq("b2b drained", 32'(IN_READY), 32'd1);
      OUT_READY = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
